// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rx_pkg.sv
// Shared types and parameter bounds for the receive-line glitch filter.
// Used by the synchronizer and the filter top.
package gf180mcu_fd_sc_mcu7t5v0__rx_pkg;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int FILT_MIN = 2;
  localparam int FILT_MAX = 255;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } rx_state_t;

  function automatic bit in_range(
    input int v,
    input int lo,
    input int hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sync_func.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Synchronous active-high reset clears the whole chain.
module gf180mcu_fd_sc_mcu7t5v0__sync_func
  import gf180mcu_fd_sc_mcu7t5v0__rx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (!in_range(DEPTH, SYNC_MIN, SYNC_MAX)) begin : g_bad_depth
    $error("sync_func: DEPTH %0d out of range", DEPTH);
  end

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[DEPTH-2:0], d};
    end
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func.sv
// Receive-line filter: synchronizes I, then qualifies each level change
// over FILT_LEN consecutive cycles before it reaches Z.
module gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func
  import gf180mcu_fd_sc_mcu7t5v0__rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  input  logic EN,
  output logic Z,
  output logic RISE,
  output logic FALL,
  output logic GLITCH,
  inout  wire  VDD,
  inout  wire  VSS
);

  if (!in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX)) begin : g_bad_sync
    $error("rxfilt: SYNC_STAGES %0d out of range", SYNC_STAGES);
  end
  if (!in_range(FILT_LEN, FILT_MIN, FILT_MAX)) begin : g_bad_filt
    $error("rxfilt: FILT_LEN %0d out of range", FILT_LEN);
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cntw
    $error("rxfilt: CNT_W %0d out of range", CNT_W);
  end else if ((64'd1 << CNT_W) <= 64'(FILT_LEN)) begin : g_small_cnt
    $error("rxfilt: CNT_W %0d too narrow", CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  wire unused_supply = VDD ^ VSS;

  logic s;

  gf180mcu_fd_sc_mcu7t5v0__sync_func #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (I),
    .q  (s)
  );

  rx_state_t        state;
  rx_state_t        state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             z_d;
  logic             rise_d;
  logic             fall_d;
  logic             glitch_d;
  logic             pend;
  logic             diff;
  logic             done;
  logic             abandon;

  assign pend    = (state == PEND_HI) || (state == PEND_LO);
  assign diff    = s ^ Z;
  assign done    = EN && pend && diff && (cnt == LAST);
  assign abandon = EN && pend && !diff;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      Z      <= 1'b0;
      RISE   <= 1'b0;
      FALL   <= 1'b0;
      GLITCH <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      Z      <= z_d;
      RISE   <= rise_d;
      FALL   <= fall_d;
      GLITCH <= glitch_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (!EN) begin
      // frozen: drop any pending change silently
      state_d = Z ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      unique case (state)
        STABLE_LO: begin
          if (s) begin
            state_d = PEND_HI;
            cnt_d   = ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_d = PEND_LO;
            cnt_d   = ONE;
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt == LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
        PEND_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt == LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    z_d      = Z;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    unique case (1'b1)
      done: begin
        z_d    = s;
        rise_d = s;
        fall_d = !s;
      end
      abandon: begin
        glitch_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func.sv
// Directed and randomized checks of the receive-line filter against
// a run-length reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func;

  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic clk = 1'b0;
  logic rst;
  logic i;
  logic en;
  logic z;
  logic rise;
  logic fall;
  logic glitch;

  logic rst2;
  logic i2;
  logic z2;
  logic rise2;
  logic fall2;
  logic glitch2;

  wire vdd;
  wire vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit sq[$];
  int run;
  bit mz;
  bit mr;
  bit mf;
  bit mg;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func dut (
    .CLK   (clk),
    .RST   (rst),
    .I     (i),
    .EN    (en),
    .Z     (z),
    .RISE  (rise),
    .FALL  (fall),
    .GLITCH(glitch),
    .VDD   (vdd),
    .VSS   (vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func #(
    .SYNC_STAGES(3),
    .FILT_LEN   (2),
    .CNT_W      (8)
  ) dut2 (
    .CLK   (clk),
    .RST   (rst2),
    .I     (i2),
    .EN    (1'b1),
    .Z     (z2),
    .RISE  (rise2),
    .FALL  (fall2),
    .GLITCH(glitch2),
    .VDD   (vdd),
    .VSS   (vss)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One rising edge: advance the model with the inputs seen at the edge,
  // then compare the DUT shortly after the edge.
  task automatic tick();
    bit s;
    @(posedge clk);
    mr = 0;
    mf = 0;
    mg = 0;
    if (rst) begin
      sq = {};
      repeat (SYNC) sq.push_back(1'b0);
      mz  = 0;
      run = 0;
    end else begin
      s = sq.pop_front();
      sq.push_back(i);
      if (!en) begin
        run = 0;
      end else if (s != mz) begin
        run++;
        if (run == FILT) begin
          mz  = s;
          mr  = s;
          mf  = !s;
          run = 0;
        end
      end else begin
        mg  = (run > 0);
        run = 0;
      end
    end
    #1;
    chk("z", 32'(z), 32'(mz));
    chk("rise", 32'(rise), 32'(mr));
    chk("fall", 32'(fall), 32'(mf));
    chk("glitch", 32'(glitch), 32'(mg));
    chk("excl", 32'((32'(rise) + 32'(fall) + 32'(glitch)) <= 1), 1);
    chk("cnt_bound", 32'(32'(dut.cnt) < FILT), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int gcnt;
    int pcnt;
    rst  = 1'b1;
    i    = 1'b0;
    en   = 1'b1;
    rst2 = 1'b1;
    i2   = 1'b0;
    #2;

    // reset state
    do_reset();
    chk("rst_z", 32'(z), 0);
    chk("rst_pulses", 32'({rise, fall, glitch}), 0);

    // clean rise: Z and RISE on the 6th edge, RISE gone on the 7th
    i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rise_lat_z%0d", k), 32'(z), 32'(k >= 6));
      chk($sformatf("rise_lat_p%0d", k), 32'(rise), 32'(k == 6));
    end

    // short low pulse on a high line: one GLITCH, no level change
    repeat (4) tick();
    i = 1'b0;
    gcnt = 0;
    pcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) i = 1'b1;
      tick();
      gcnt += 32'(glitch);
      pcnt += 32'(rise) + 32'(fall);
      chk($sformatf("glitch_z%0d", k), 32'(z), 1);
    end
    chk("glitch_count", 32'(gcnt), 1);
    chk("glitch_edges", 32'(pcnt), 0);

    // reset in the middle of a pending rise
    do_reset();
    i = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_z", 32'(z), 0);
    chk("midrst_p", 32'({rise, fall, glitch}), 0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("midrst_lat%0d", k), 32'(z), 32'(k == 6));
    end

    // enable dropped mid-pending: no pulse, restart after EN
    do_reset();
    i = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("en_off_z%0d", k), 32'(z), 0);
      chk($sformatf("en_off_p%0d", k), 32'({rise, fall, glitch}), 0);
    end
    en = 1'b1;
    for (int k = 1; k <= FILT; k++) begin
      tick();
      chk($sformatf("en_on_z%0d", k), 32'(z), 32'(k == FILT));
    end

    // SYNC_STAGES=3, FILT_LEN=2: clean fall lands 5 edges later
    rst = 1'b1;
    tick();
    tick();
    rst2 = 1'b0;
    i2   = 1'b1;
    repeat (8) tick();
    chk("d2_high", 32'(z2), 1);
    i2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("d2_fall_z%0d", k), 32'(z2), 32'(k < 5));
      chk($sformatf("d2_fall_p%0d", k), 32'(fall2), 32'(k == 5));
      chk($sformatf("d2_other%0d", k), 32'({rise2, glitch2}), 0);
    end
    rst = 1'b0;

    // random line activity against the model
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(3) == 0) i = ~i;
      en  = ($urandom_range(31) != 0);
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 1'b0;
    en  = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func.md
GF180MCU_FD_SC_MCU7T5V0__RXFILT_1_FUNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__rxfilt_1_func

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on I; legal values 2..4.
REQ-002 Parameter FILT_LEN, default 4, SHALL set the consecutive synchronized-cycle count that qualifies an edge; legal values 2..255.
REQ-003 Parameter CNT_W, default 8, SHALL set the filter counter width; it SHALL satisfy 2**CNT_W > FILT_LEN.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 I  input  1  asynchronous buffered line being received.
REQ-007 EN  input  1  filter enable; when low, the filter is frozen.
REQ-008 Z  output  1  filtered, synchronized level of I; registered.
REQ-009 RISE  output  1  one-cycle pulse in the cycle Z goes 0->1.
REQ-010 FALL  output  1  one-cycle pulse in the cycle Z goes 1->0.
REQ-011 GLITCH  output  1  one-cycle pulse when a pending transition is abandoned.
REQ-012 VDD, VSS  inout  1  supply pins; functionally unused.

Function
REQ-013 I SHALL pass through a SYNC_STAGES-deep flop chain; its final stage S is the only value the filter observes.
REQ-014 The FSM SHALL have exactly four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-015 In STABLE_LO with S=1 (STABLE_HI with S=0), the FSM SHALL enter PEND_HI (PEND_LO) and load the counter CNT=1.
REQ-016 In PEND_x with S still differing from Z and CNT<FILT_LEN-1, the FSM SHALL increment CNT.
REQ-017 In PEND_x with S differing from Z and CNT=FILT_LEN-1, the FSM SHALL update Z to S, pulse RISE or FALL, enter STABLE_x of the new level, and clear CNT.
REQ-018 In PEND_x with S equal to Z, the FSM SHALL return to the prior STABLE state, clear CNT, pulse GLITCH, and leave Z unchanged.
REQ-019 The latency from a clean I edge held stable to the Z change SHALL be exactly SYNC_STAGES+FILT_LEN rising edges.
REQ-020 The RISE, FALL and GLITCH pulses SHALL be registered, asserted in the same cycle as the corresponding Z/state update, and mutually exclusive.
REQ-021 With EN=0, the synchronizer SHALL keep running, the FSM SHALL force the STABLE state matching Z, CNT SHALL be 0, and the pulses SHALL stay 0; any pending transition SHALL be dropped without a GLITCH pulse.
REQ-022 The counter SHALL never wrap; values above FILT_LEN-1 SHALL be unreachable.
REQ-023 An input pulse shorter than FILT_LEN synchronized cycles SHALL never reach Z.

Reset
REQ-024 While RST=1 at a rising edge, the following SHALL be cleared: all sync flops to 0, Z=0, RISE=FALL=GLITCH=0, CNT=0, and state to STABLE_LO.
REQ-025 RST SHALL take priority over EN and over the FSM.
REQ-026 A reset asserted mid-pending SHALL abort the transition with no pulse.
REQ-027 The first evaluation after RST falls SHALL use synchronizer contents refilled from 0.

Structure
REQ-028 The state enumeration and the SYNC_STAGES/FILT_LEN bound constants SHALL reside in package gf180mcu_fd_sc_mcu7t5v0__rx_pkg.
REQ-029 The synchronizer SHALL be a sub-module, gf180mcu_fd_sc_mcu7t5v0__sync_func, parameterized by depth, with synchronous active-high reset.
REQ-030 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-031 Defaults; after reset, raise I and hold -> Z=1 and RISE=1 on the 6th rising edge; RISE is low in the next cycle.
REQ-032 Defaults, Z=1; drop I low for 3 cycles, then restore -> GLITCH pulses once; Z, FALL and RISE stay constant.
REQ-033 FILT_LEN=2, SYNC_STAGES=3; apply a clean fall -> Z=0 and FALL=1 exactly 5 edges after the I edge.
REQ-034 Defaults; raise I, then assert RST on the 4th edge for 1 cycle while I stays high -> Z=0 and no pulses during reset; Z=1 six edges after RST deasserts.
REQ-035 Defaults; raise I, then drop EN at the 4th edge for 5 cycles -> Z stays 0 with no pulses; Z=1 FILT_LEN edges after EN rises.
REQ-036 Random I toggling for 10k cycles -> Z equals a reference model, pulse exclusivity holds, and CNT<FILT_LEN always.
